// File: rtl/data_sync_bus_filter_synth.sv
`default_nettype none
// ============================================================================
// Module      : data_sync_bus_filter_synth
// Description : WIDTH-channel synchronizer with per-bit reset value, optional
//               per-bit or bus-coherent stability filter, and rise/fall pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module data_sync_bus_filter_synth #(
    parameter int               WIDTH         = 8,
    parameter int               NUM_FLOPS     = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE   = {WIDTH{1'b0}},
    parameter int               FILTER_CYCLES = 0,
    parameter int               MODE          = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    localparam int c_cnt_w = (FILTER_CYCLES > 0) ? $clog2(FILTER_CYCLES + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last =
        c_cnt_w'((FILTER_CYCLES > 0) ? (FILTER_CYCLES - 1) : 0);

    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("data_sync_bus_filter_synth: WIDTH must be 1..64");
    end
    if (NUM_FLOPS < 1 || NUM_FLOPS > 8) begin : g_bad_flops
        $error("data_sync_bus_filter_synth: NUM_FLOPS must be 1..8");
    end
    if (FILTER_CYCLES < 0 || FILTER_CYCLES > 255) begin : g_bad_filter
        $error("data_sync_bus_filter_synth: FILTER_CYCLES must be 0..255");
    end
    if (MODE != 0 && MODE != 1) begin : g_bad_mode
        $error("data_sync_bus_filter_synth: MODE must be 0 or 1");
    end
    if (MODE == 1 && FILTER_CYCLES == 0) begin : g_bad_mode_f
        $error("data_sync_bus_filter_synth: MODE=1 requires FILTER_CYCLES>0");
    end

    logic [WIDTH-1:0] s;

    // Plain flop-to-flop chain; set/clear flavour picked per bit from RESET_VALUE.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chain
        (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE" *)
        logic [NUM_FLOPS-1:0] sync_q;
        logic [NUM_FLOPS-1:0] sync_d;

        always_comb begin
            sync_d[0] = d_in[gi];
            for (int k = 1; k < NUM_FLOPS; k++) begin
                sync_d[k] = sync_q[k-1];
            end
        end

        if (RESET_VALUE[gi]) begin : g_set
            always_ff @(posedge clock or posedge reset) begin
                if (reset) sync_q <= '1;
                else       sync_q <= sync_d;
            end
        end else begin : g_clr
            always_ff @(posedge clock or posedge reset) begin
                if (reset) sync_q <= '0;
                else       sync_q <= sync_d;
            end
        end

        assign s[gi] = sync_q[NUM_FLOPS-1];
    end

    if (FILTER_CYCLES == 0) begin : g_bypass
        assign d_out = s;
    end else if (MODE == 0) begin : g_bit_filter
        logic [c_cnt_w-1:0] cnt_q [WIDTH];
        logic [c_cnt_w-1:0] cnt_d [WIDTH];
        logic [WIDTH-1:0]   filt_q;
        logic [WIDTH-1:0]   filt_d;

        always_comb begin
            filt_d = filt_q;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_d[i] = cnt_q[i];
                if (s[i] == filt_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == c_cnt_last) begin
                    filt_d[i] = s[i];
                    cnt_d[i]  = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + c_cnt_w'(1);
                end
            end
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                filt_q <= RESET_VALUE;
                for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
            end else begin
                filt_q <= filt_d;
                for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
            end
        end

        assign d_out = filt_q;
    end else begin : g_bus_filter
        logic [c_cnt_w-1:0] cnt_q;
        logic [c_cnt_w-1:0] cnt_d;
        logic [WIDTH-1:0]   s_q;
        logic [WIDTH-1:0]   filt_q;
        logic [WIDTH-1:0]   filt_d;

        // Any movement on the bus restarts the count, so the whole word lands at once.
        always_comb begin
            filt_d = filt_q;
            cnt_d  = cnt_q;
            if (s == filt_q || s != s_q) begin
                cnt_d = '0;
            end else if (cnt_q == c_cnt_last) begin
                filt_d = s;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + c_cnt_w'(1);
            end
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                cnt_q  <= '0;
                s_q    <= RESET_VALUE;
                filt_q <= RESET_VALUE;
            end else begin
                cnt_q  <= cnt_d;
                s_q    <= s;
                filt_q <= filt_d;
            end
        end

        assign d_out = filt_q;
    end

    logic [WIDTH-1:0] d_out_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) d_out_q <= RESET_VALUE;
        else       d_out_q <= d_out;
    end

    assign rise    = d_out & ~d_out_q;
    assign fall    = ~d_out & d_out_q;
    assign changed = |(rise | fall);

endmodule
`default_nettype wire

// File: tb/tb_data_sync_bus_filter_synth.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_sync_bus_filter_synth
// Description : Three configurations (per-bit filter, bypass, bus-coherent)
//               checked cycle by cycle against a sample-window reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_sync_bus_filter_synth;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [7:0]       d_in  = 8'hA5;
    logic [2:0][7:0]  dout_v, rise_v, fall_v;
    logic [2:0]       chg_v;

    int         checks = 0;
    int         passes = 0;
    int         fails  = 0;

    int         nf [3] = '{2, 3, 2};
    int         ff [3] = '{4, 0, 3};
    int         md [3] = '{0, 0, 1};
    logic [7:0] rv [3] = '{8'hA5, 8'h5A, 8'hFF};

    logic [7:0] chain [3][8];
    logic [7:0] hist  [3][16];
    int         hcnt  [3];
    logic [7:0] m_d   [3];
    logic [7:0] m_prev[3];

    always #5 clock = ~clock;

    data_sync_bus_filter_synth #(.WIDTH(8), .NUM_FLOPS(2), .RESET_VALUE(8'hA5),
        .FILTER_CYCLES(4), .MODE(0)) u_bit (
        .clock(clock), .reset(reset), .d_in(d_in), .d_out(dout_v[0]),
        .rise(rise_v[0]), .fall(fall_v[0]), .changed(chg_v[0]));

    data_sync_bus_filter_synth #(.WIDTH(8), .NUM_FLOPS(3), .RESET_VALUE(8'h5A),
        .FILTER_CYCLES(0), .MODE(0)) u_byp (
        .clock(clock), .reset(reset), .d_in(d_in), .d_out(dout_v[1]),
        .rise(rise_v[1]), .fall(fall_v[1]), .changed(chg_v[1]));

    data_sync_bus_filter_synth #(.WIDTH(8), .NUM_FLOPS(2), .RESET_VALUE(8'hFF),
        .FILTER_CYCLES(3), .MODE(1)) u_bus (
        .clock(clock), .reset(reset), .d_in(d_in), .d_out(dout_v[2]),
        .rise(rise_v[2]), .fall(fall_v[2]), .changed(chg_v[2]));

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 8; j++) chain[k][j] = rv[k];
            for (int j = 0; j < 16; j++) hist[k][j] = rv[k];
            hcnt[k]   = 0;
            m_d[k]    = rv[k];
            m_prev[k] = rv[k];
        end
    endtask

    // d_out takes a new value only once the last F (per bit) or F+1 (whole
    // bus, all identical) synchronized samples all disagree with it.
    task automatic model_edge(input logic [7:0] din);
        logic [7:0] s_pre;
        logic       ok;
        for (int k = 0; k < 3; k++) begin
            s_pre = chain[k][nf[k]-1];
            for (int j = 7; j > 0; j--) chain[k][j] = chain[k][j-1];
            chain[k][0] = din;
            m_prev[k] = m_d[k];
            if (ff[k] == 0) begin
                m_d[k] = chain[k][nf[k]-1];
            end else begin
                for (int j = 15; j > 0; j--) hist[k][j] = hist[k][j-1];
                hist[k][0] = s_pre;
                if (hcnt[k] < 16) hcnt[k]++;
                if (md[k] == 0) begin
                    for (int b = 0; b < 8; b++) begin
                        ok = (hcnt[k] >= ff[k]);
                        for (int j = 0; j < ff[k]; j++)
                            if (hist[k][j][b] == m_prev[k][b]) ok = 1'b0;
                        if (ok) m_d[k][b] = s_pre[b];
                    end
                end else begin
                    ok = (hcnt[k] >= ff[k] + 1) && (s_pre != m_prev[k]);
                    for (int j = 0; j <= ff[k]; j++)
                        if (hist[k][j] != s_pre) ok = 1'b0;
                    if (ok) m_d[k] = s_pre;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input int k, input logic [7:0] obs,
                       input logic [7:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("FAIL %s[u%0d] t=%0t: observed %h expected %h", tag, k, $time, obs, expv);
        end
    endtask

    task automatic check_all();
        logic [7:0] er, ef;
        for (int k = 0; k < 3; k++) begin
            er = m_d[k] & ~m_prev[k];
            ef = ~m_d[k] & m_prev[k];
            chk("d_out", k, dout_v[k], m_d[k]);
            chk("rise", k, rise_v[k], er);
            chk("fall", k, fall_v[k], ef);
            chk("changed", k, {7'd0, chg_v[k]}, {7'd0, |(er | ef)});
        end
    endtask

    // Entered and left at a falling edge; input changes away from the rising edge.
    task automatic cyc(input logic [7:0] v);
        d_in = v;
        @(posedge clock);
        if (!reset) model_edge(v);
        #1;
        check_all();
        @(negedge clock);
    endtask

    task automatic hold(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) cyc(v);
    endtask

    task automatic pulse_reset(input int n);
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        hold(d_in, n);
        reset = 1'b0;
    endtask

    task automatic skewed(input logic [7:0] target);
        logic [7:0] m;
        logic [7:0] v;
        m = 8'h00;
        for (int b = 0; b < 8; b++) begin
            m[b] = 1'b1;
            v = (d_in & ~m) | (target & m);
            if (v != d_in) cyc(v);
        end
    endtask

    initial begin
        logic [7:0] v;
        int         r;
        model_reset();
        @(negedge clock);
        #1;
        check_all();
        hold(8'hA5, 2);
        reset = 1'b0;
        hold(8'hA5, 10);

        // Short glitch on bit 0, then a held change
        hold(8'hA4, 3);
        hold(8'hA5, 8);
        hold(8'hA4, 10);

        // Skewed arrival toward a new bus value
        hold(8'h00, 10);
        skewed(8'h3C);
        hold(8'h3C, 10);

        // Reset in the middle of a filter count
        hold(8'hF0, 4);
        pulse_reset(2);
        hold(8'hF0, 12);

        // Falling path toward all-ones reset value of the bus instance
        hold(8'hFF, 10);
        hold(8'hFE, 10);

        for (int it = 0; it < 150; it++) begin
            r = $urandom_range(0, 4);
            case (r)
                0: hold(8'($urandom), $urandom_range(1, 10));
                1: begin
                    v = d_in;
                    v[$urandom_range(0, 7)] ^= 1'b1;
                    hold(v, $urandom_range(1, 4));
                    hold(d_in ^ (v ^ d_in), 0);
                end
                2: skewed(8'($urandom));
                3: hold(d_in, $urandom_range(1, 6));
                default: begin
                    if ($urandom_range(0, 9) == 0) pulse_reset($urandom_range(1, 3));
                    else cyc(8'($urandom));
                end
            endcase
        end
        hold(d_in, 10);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
